uart_serializer_param: RTL and testbench

Parametrised parallel-to-serial converter for the UART TX path. It accepts a DATA_WIDTH-bit word through a valid/ready handshake and shifts it out one bit per SER_EN strobe. The TX FSM or baud-tick generator drives SER_EN. Bit order is selectable. A one-word holding buffer lets back-to-back frames shift with no idle gap. SER_DONE tells the TX FSM to move to the parity or stop state.

---
 rtl/uart_serializer_param.sv | 104 ++++++++++
 tb/tb_uart_serializer_param.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/uart_serializer_param.sv
// Parallel-to-serial converter for the UART TX path: a one-word holding buffer
// feeds a shift register so consecutive words leave with no idle bit between them.
module uart_serializer_param #(
  parameter int DATA_WIDTH = 8,
  parameter bit LSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  output logic                  LOAD_READY,
  input  logic                  SER_EN,
  output logic                  SER_DATA,
  output logic                  SER_DONE,
  output logic                  BUSY,
  output logic                  dbg_state_o
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] hold_q;
  logic                  hold_valid_q;
  logic                  load_ready_q;
  logic [DATA_WIDTH-1:0] sh_q;
  logic [DATA_WIDTH-1:0] sh_d;
  logic [CW-1:0]         cnt_q;
  logic                  done_q;

  // Shift toward the output end with zero fill.
  always_comb begin
    sh_d = sh_q;
    if (LSB_FIRST) sh_d = sh_q >> 1;
    else           sh_d = sh_q << 1;
  end

  // Handshake: a word transfers on any rising edge where DATA_VALID and
  // LOAD_READY are both high; LOAD_READY is a flop mirroring an empty buffer,
  // and an unaccepted DATA_VALID must keep P_DATA stable until it transfers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      load_ready_q <= 1'b1;
      sh_q         <= '0;
      cnt_q        <= '0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (DATA_VALID && load_ready_q) begin
        hold_q       <= P_DATA;
        hold_valid_q <= 1'b1;
        load_ready_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (hold_valid_q) begin
            sh_q         <= hold_q;
            hold_valid_q <= 1'b0;
            load_ready_q <= 1'b1;
            cnt_q        <= '0;
            state_q      <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (SER_EN) begin
            if (cnt_q == LAST) begin
              done_q <= 1'b1;
              // A buffered word continues the stream on the very next bit.
              if (hold_valid_q) begin
                sh_q         <= hold_q;
                hold_valid_q <= 1'b0;
                load_ready_q <= 1'b1;
                cnt_q        <= '0;
              end else begin
                state_q <= S_IDLE;
              end
            end else begin
              sh_q  <= sh_d;
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign LOAD_READY  = load_ready_q;
  assign SER_DONE    = done_q;
  assign BUSY        = (state_q == S_SHIFT) || hold_valid_q;
  assign SER_DATA    = (state_q == S_SHIFT) ?
                       (LSB_FIRST ? sh_q[0] : sh_q[DATA_WIDTH-1]) : IDLE_LEVEL;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_serializer_param.sv
// Directed bench for uart_serializer_param: three instances cover LSB-first,
// MSB-first with a high idle level, and a 12-bit payload.
module tb_uart_serializer_param;

  logic        clk;
  logic [2:0]  rst, en, valid;
  logic [2:0]  ready, sdata, done, busy, dbg;
  logic [15:0] pd [3];

  localparam logic [2:0] IDLE_LV = 3'b010;

  int n_vec = 0;
  int n_err = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_serializer_param #(.DATA_WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_a (
    .CLK(clk), .RST(rst[0]), .P_DATA(pd[0][7:0]), .DATA_VALID(valid[0]),
    .LOAD_READY(ready[0]), .SER_EN(en[0]), .SER_DATA(sdata[0]),
    .SER_DONE(done[0]), .BUSY(busy[0]), .dbg_state_o(dbg[0]));

  uart_serializer_param #(.DATA_WIDTH(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_b (
    .CLK(clk), .RST(rst[1]), .P_DATA(pd[1][7:0]), .DATA_VALID(valid[1]),
    .LOAD_READY(ready[1]), .SER_EN(en[1]), .SER_DATA(sdata[1]),
    .SER_DONE(done[1]), .BUSY(busy[1]), .dbg_state_o(dbg[1]));

  uart_serializer_param #(.DATA_WIDTH(12), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_c (
    .CLK(clk), .RST(rst[2]), .P_DATA(pd[2][11:0]), .DATA_VALID(valid[2]),
    .LOAD_READY(ready[2]), .SER_EN(en[2]), .SER_DATA(sdata[2]),
    .SER_DONE(done[2]), .BUSY(busy[2]), .dbg_state_o(dbg[2]));

  // driver: offer one word while the buffer is empty, then release DATA_VALID
  task automatic offer(input int d, input logic [15:0] word);
    @(negedge clk);
    pd[d]    = word;
    valid[d] = 1'b1;
    @(negedge clk);
    valid[d] = 1'b0;
    n_vec++;
    if ({ready[d], busy[d]} !== 2'b01) begin
      n_err++;
      $display("FAIL accept dut%0d: ready/busy=%b want 01", d, {ready[d], busy[d]});
    end
  endtask

  // seq[i] is the i-th bit expected on SER_DATA; one strobe every gap cycles
  task automatic shift_bits(input int d, input int count, input logic [15:0] seq,
                            input int gap);
    for (int i = 0; i < count; i++) begin
      for (int k = 0; k < gap; k++) begin
        @(negedge clk);
        n_vec++;
        if ({sdata[d], done[d], busy[d], dbg[d]} !== {seq[i], 1'b0, 1'b1, 1'b1}) begin
          n_err++;
          $display("FAIL shift dut%0d bit%0d: data/done/busy/state=%b want %b",
                   d, i, {sdata[d], done[d], busy[d], dbg[d]}, {seq[i], 3'b011});
        end
        en[d] = (k == gap - 1);
      end
    end
  endtask

  // after the final strobe: one SER_DONE pulse, back to idle, then SER_DONE low
  task automatic expect_done_idle(input int d);
    @(negedge clk);
    en[d] = 1'b0;
    n_vec++;
    if ({sdata[d], done[d], ready[d], busy[d]} !== {IDLE_LV[d], 3'b110}) begin
      n_err++;
      $display("FAIL done_pulse dut%0d: data/done/ready/busy=%b want %b",
               d, {sdata[d], done[d], ready[d], busy[d]}, {IDLE_LV[d], 3'b110});
    end
    @(negedge clk);
    n_vec++;
    if (done[d] !== 1'b0) begin
      n_err++;
      $display("FAIL done_width dut%0d: done=%b want 0", d, done[d]);
    end
  endtask

  task automatic test_reset();
    rst = 3'b111; en = 3'b000; valid = 3'b000;
    for (int d = 0; d < 3; d++) pd[d] = 16'h0000;
    repeat (2) @(negedge clk);
    rst = 3'b000;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        n_vec++;
        if ({ready[d], busy[d], done[d], sdata[d]} !== {3'b100, IDLE_LV[d]}) begin
          n_err++;
          $display("FAIL reset_idle dut%0d cyc%0d: ready/busy/done/data=%b want %b",
                   d, c, {ready[d], busy[d], done[d], sdata[d]}, {3'b100, IDLE_LV[d]});
        end
      end
      en = (c < 3) ? 3'b111 : 3'b000;  // strobes in IDLE must do nothing
    end
  endtask

  task automatic test_lsb_first();
    offer(0, 16'h00B4);
    shift_bits(0, 8, 16'h00B4, 4);  // 0,0,1,0,1,1,0,1
    expect_done_idle(0);
  endtask

  task automatic test_msb_first();
    offer(1, 16'h00B4);
    shift_bits(1, 8, 16'h002D, 4);  // 1,0,1,1,0,1,0,0
    expect_done_idle(1);
  endtask

  // 0x0F, 0xF0, then 0x55 held while the buffer is full; SER_EN tied high
  task automatic test_back_to_back();
    logic [15:0] words [3];
    logic [23:0] seq;
    logic        prev_acc, exp_data, exp_done, exp_ready, exp_busy;
    int          idx;
    words[0] = 16'h000F; words[1] = 16'h00F0; words[2] = 16'h0055;
    seq = 24'h55F00F;
    idx = 0;
    prev_acc = 1'b0;
    for (int t = -1; t <= 26; t++) begin
      @(negedge clk);
      if (t >= 0) begin
        exp_data  = (t >= 1 && t <= 24) ? seq[t-1] : 1'b0;
        exp_done  = (t == 9) || (t == 17) || (t == 25);
        exp_ready = (t == 1) || (t == 9) || (t >= 17);
        exp_busy  = (t <= 24);
        n_vec++;
        if ({sdata[0], done[0], ready[0], busy[0]} !==
            {exp_data, exp_done, exp_ready, exp_busy}) begin
          n_err++;
          $display("FAIL b2b t%0d: data/done/ready/busy=%b want %b", t,
                   {sdata[0], done[0], ready[0], busy[0]},
                   {exp_data, exp_done, exp_ready, exp_busy});
        end
      end
      if (prev_acc) idx++;
      valid[0] = (idx < 3);
      pd[0]    = (idx < 3) ? words[idx] : 16'h0000;
      prev_acc = valid[0] && ready[0];
      en[0]    = (t >= 1 && t <= 24);
    end
    n_vec++;
    if (idx !== 3) begin
      n_err++;
      $display("FAIL b2b_accepts: words taken=%0d want 3", idx);
    end
  endtask

  // 12-bit word aborted by reset after five bits, with a second word buffered
  task automatic test_reset_midword();
    offer(2, 16'h0A5C);
    shift_bits(2, 5, 16'h0A5C, 2);  // 0,0,1,1,1
    @(negedge clk);
    en[2] = 1'b0; pd[2] = 16'h0FFF; valid[2] = 1'b1;
    @(negedge clk);
    valid[2] = 1'b0;
    n_vec++;
    if ({sdata[2], ready[2], busy[2]} !== 3'b001) begin
      n_err++;
      $display("FAIL pre_abort: data/ready/busy=%b want 001", {sdata[2], ready[2], busy[2]});
    end
    rst[2] = 1'b1;
    @(negedge clk);
    rst[2] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      n_vec++;
      if ({sdata[2], done[2], ready[2], busy[2], dbg[2]} !== 5'b00100) begin
        n_err++;
        $display("FAIL abort cyc%0d: data/done/ready/busy/state=%b want 00100",
                 c, {sdata[2], done[2], ready[2], busy[2], dbg[2]});
      end
      en[2] = (c < 4);
      @(negedge clk);
    end
    en[2] = 1'b0;
    offer(2, 16'h0123);
    shift_bits(2, 12, 16'h0123, 1);  // 1,1,0,0,0,1,0,0,1,0,0,0
    expect_done_idle(2);
  endtask

  initial begin
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_back_to_back();
    test_reset_midword();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
